// File: rtl/wrptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wrptr_full_ctrl
//  Purpose  : Write-side pointer, read-pointer synchroniser and full/level
//             flags for a dual-clock FIFO.
//  Revision : 1.0
// ============================================================================
module wrptr_full_ctrl #(
    parameter int PTR_WIDTH    = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 i_wr_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [PTR_WIDTH:0]   i_rdptr_gray,
    input  logic                 i_ovf_clr,
    output logic                 o_wr_accept,
    output logic [PTR_WIDTH-1:0] o_wraddr,
    output logic [PTR_WIDTH:0]   o_wrptr_bin,
    output logic [PTR_WIDTH:0]   o_wrptr_gray,
    output logic                 o_full,
    output logic                 o_almost_full,
    output logic [PTR_WIDTH:0]   o_level,
    output logic                 o_overflow
);

    // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted
    localparam logic [PTR_WIDTH:0] c_FULL_MASK = (PTR_WIDTH+1)'(3) << (PTR_WIDTH-1);
    localparam logic [PTR_WIDTH:0] c_AFULL     = (PTR_WIDTH+1)'(AFULL_THRESH);

    logic [PTR_WIDTH:0] wbin_q, wbin_d;
    logic [PTR_WIDTH:0] wgray_q, wgray_d;
    logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [PTR_WIDTH:0] rq_gray, rq_bin;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic               full_q, full_d;
    logic               afull_q, afull_d;
    logic               ovf_q, ovf_d;
    logic               wr_accept;

    assign rq_gray   = sync_q[SYNC_STAGES-1];
    assign wr_accept = i_wr_en & ~full_q;

    always_comb begin
        rq_bin = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            rq_bin[i] = ^(rq_gray >> i);
        end
    end

    always_comb begin
        wbin_d  = wbin_q + {{PTR_WIDTH{1'b0}}, wr_accept};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        level_d = wbin_d - rq_bin;
        full_d  = (wgray_d == (rq_gray ^ c_FULL_MASK));
        afull_d = (level_d >= c_AFULL);
        // A blocked write in the same cycle as a clear keeps the flag set
        if (i_wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge i_wr_clk or posedge i_rst) begin
        if (i_rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            wbin_q    <= wbin_d;
            wgray_q   <= wgray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            sync_q[0] <= i_rdptr_gray;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign o_wr_accept   = wr_accept;
    assign o_wraddr      = wbin_q[PTR_WIDTH-1:0];
    assign o_wrptr_bin   = wbin_q;
    assign o_wrptr_gray  = wgray_q;
    assign o_full        = full_q;
    assign o_almost_full = afull_q;
    assign o_level       = level_q;
    assign o_overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wrptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wrptr_full_ctrl
//  Purpose  : Directed and random checks of wrptr_full_ctrl against a
//             counter-based occupancy model.
//  Revision : 1.0
// ============================================================================
module tb_wrptr_full_ctrl;

    logic       clk = 1'b0;
    bit         clk_en = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] rdptr_gray = '0;
    logic       ovf_clr = 1'b0;
    logic       wr_accept;
    logic [2:0] wraddr;
    logic [3:0] wrptr_bin, wrptr_gray, level;
    logic       full, almost_full, overflow;

    int n_vec = 0;
    int n_err = 0;

    // Model state: write count, delayed read pointers (binary), flags
    int m_wbin, m_s0, m_s1, m_level;
    bit m_full, m_afull, m_ovf;
    int rd_bin;
    bit saw_wrap;

    always #5 if (clk_en) clk = ~clk;

    wrptr_full_ctrl #(.PTR_WIDTH(3), .SYNC_STAGES(2), .AFULL_THRESH(6)) dut (
        .i_wr_clk     (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_rdptr_gray (rdptr_gray),
        .i_ovf_clr    (ovf_clr),
        .o_wr_accept  (wr_accept),
        .o_wraddr     (wraddr),
        .o_wrptr_bin  (wrptr_bin),
        .o_wrptr_gray (wrptr_gray),
        .o_full       (full),
        .o_almost_full(almost_full),
        .o_level      (level),
        .o_overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wbin = 0; m_s0 = 0; m_s1 = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input bit we, input int rdb, input bit clr);
        bit acc;
        acc = we && !m_full;
        if (we && m_full) m_ovf = 1;
        else if (clr)     m_ovf = 0;
        m_wbin  = (m_wbin + int'(acc)) % 16;
        m_level = (m_wbin - m_s1 + 16) % 16;
        m_full  = (m_level == 8);
        m_afull = (m_level >= 6);
        m_s1 = m_s0;
        m_s0 = rdb;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ":bin"},   wrptr_bin, m_wbin);
        chk({ph, ":gray"},  wrptr_gray, m_wbin ^ (m_wbin >> 1));
        chk({ph, ":addr"},  wraddr, m_wbin % 8);
        chk({ph, ":full"},  full, m_full);
        chk({ph, ":afull"}, almost_full, m_afull);
        chk({ph, ":level"}, level, m_level);
        chk({ph, ":ovf"},   overflow, m_ovf);
    endtask

    // One clock cycle, starting and ending just after a falling edge
    task automatic cycle(input string ph, input bit we, input int rdb, input bit clr);
        logic [3:0] g_before;
        wr_en = we;
        rdptr_gray = 4'(rdb ^ (rdb >> 1));
        ovf_clr = clr;
        #1;
        chk({ph, ":accept"}, wr_accept, we && !m_full);
        g_before = wrptr_gray;
        @(posedge clk);
        model_edge(we, rdb, clr);
        #1;
        check_outputs(ph);
        chk({ph, ":gray_step"}, $countones(wrptr_gray ^ g_before), (wrptr_gray != g_before) ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        rd_bin = 0;
        saw_wrap = 0;

        // 1. Asynchronous reset with no clock running
        #1 rst = 1'b1;
        #2;
        check_outputs("reset");
        chk("reset:accept", wr_accept, 0);
        rst = 1'b0;
        #2 clk_en = 1'b1;
        @(negedge clk);
        cycle("idle", 0, 0, 0);

        // 2. Fill to full
        for (int i = 1; i <= 8; i++) begin
            cycle("fill", 1, 0, 0);
            if (i == 6) begin
                chk("fill6:afull", almost_full, 1);
                chk("fill6:level", level, 6);
            end
        end
        chk("fill8:full", full, 1);
        chk("fill8:bin", wrptr_bin, 4'b1000);
        chk("fill8:gray", wrptr_gray, 4'b1100);
        chk("fill8:level", level, 8);

        // 3. Overflow set / clear / set-beats-clear
        cycle("ovf_set", 1, 0, 0);
        chk("ovf_set:bin", wrptr_bin, 4'b1000);
        chk("ovf_set:flag", overflow, 1);
        cycle("ovf_clr", 0, 0, 1);
        chk("ovf_clr:flag", overflow, 0);
        cycle("ovf_both", 1, 0, 1);
        chk("ovf_both:flag", overflow, 1);

        // 4. Read pointer moves to 3; full clears three edges later
        cycle("drain1", 0, 3, 0);
        cycle("drain2", 0, 3, 0);
        chk("drain2:full", full, 1);
        cycle("drain3", 0, 3, 0);
        chk("drain3:full", full, 0);
        chk("drain3:level", level, 5);
        chk("drain3:afull", almost_full, 0);

        // 5. Wrap with the reader keeping pace
        rd_bin = m_wbin;
        for (int i = 0; i < 3; i++) cycle("catchup", 0, rd_bin, 0);
        for (int i = 0; i < 20; i++) begin
            rd_bin = m_wbin;
            cycle("wrap", 1, rd_bin, 0);
            chk("wrap:nofull", full, 0);
            if (m_wbin == 0) begin
                saw_wrap = 1;
                chk("wrap:gray0", wrptr_gray, 4'b0000);
                chk("wrap:addr0", wraddr, 0);
            end
        end
        chk("wrap:seen", saw_wrap, 1);

        // Random traffic: reader advances only over data already written
        for (int i = 0; i < 300; i++) begin
            int avail;
            avail = (m_wbin - rd_bin + 16) % 16;
            if (avail > 0 && $urandom_range(0, 2) == 0)
                rd_bin = (rd_bin + $urandom_range(1, avail)) % 16;
            cycle("rand", 1'($urandom_range(0, 1)), rd_bin, ($urandom_range(0, 7) == 0));
        end

        // 6. Asynchronous reset mid-operation while full with overflow set
        for (int i = 0; i < 12; i++) cycle("refill", 1, rd_bin, 0);
        chk("refill:full", full, 1);
        chk("refill:ovf", overflow, 1);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("midreset");
        rdptr_gray = '0;
        wr_en = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        rd_bin = 0;
        chk("resume:addr_pre", wraddr, 0);
        cycle("resume", 1, 0, 0);
        chk("resume:addr", wraddr, 1);
        cycle("resume", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
